ps2_scancode_decoder: RTL and testbench

//  Consumes raw PS/2 set-2 scan-code bytes from the keyboard receiver FIFO output.

---
 rtl/ps2_scancode_decoder_pkg.sv | 24 ++
 rtl/ps2_scancode_decoder_ascii.sv | 82 ++++++++
 rtl/ps2_scancode_decoder.sv | 128 ++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code decoder.
// Holds the prefix-folding FSM states, special codes and the ignored-code test.
package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Error, BAT-complete, ack and echo bytes carry no key information.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == 8'h00) || (code == 8'hFF) || (code == 8'hAA) ||
               (code == 8'hFA) || (code == 8'hEE);
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_ascii.sv
// Combinational set-2 scan code to ASCII lookup.
// Letters follow shift^caps; digits and punctuation follow shift only; unmapped codes give 0.
module scancode_to_ascii (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic       letter;
    logic [7:0] lower;
    logic [7:0] plain;
    logic [7:0] shifted;

    always_comb begin
        letter  = 1'b0;
        lower   = 8'h00;
        plain   = 8'h00;
        shifted = 8'h00;
        case (code)
            8'h1C: begin letter = 1'b1; lower = "a"; end
            8'h32: begin letter = 1'b1; lower = "b"; end
            8'h21: begin letter = 1'b1; lower = "c"; end
            8'h23: begin letter = 1'b1; lower = "d"; end
            8'h24: begin letter = 1'b1; lower = "e"; end
            8'h2B: begin letter = 1'b1; lower = "f"; end
            8'h34: begin letter = 1'b1; lower = "g"; end
            8'h33: begin letter = 1'b1; lower = "h"; end
            8'h43: begin letter = 1'b1; lower = "i"; end
            8'h3B: begin letter = 1'b1; lower = "j"; end
            8'h42: begin letter = 1'b1; lower = "k"; end
            8'h4B: begin letter = 1'b1; lower = "l"; end
            8'h3A: begin letter = 1'b1; lower = "m"; end
            8'h31: begin letter = 1'b1; lower = "n"; end
            8'h44: begin letter = 1'b1; lower = "o"; end
            8'h4D: begin letter = 1'b1; lower = "p"; end
            8'h15: begin letter = 1'b1; lower = "q"; end
            8'h2D: begin letter = 1'b1; lower = "r"; end
            8'h1B: begin letter = 1'b1; lower = "s"; end
            8'h2C: begin letter = 1'b1; lower = "t"; end
            8'h3C: begin letter = 1'b1; lower = "u"; end
            8'h2A: begin letter = 1'b1; lower = "v"; end
            8'h1D: begin letter = 1'b1; lower = "w"; end
            8'h22: begin letter = 1'b1; lower = "x"; end
            8'h35: begin letter = 1'b1; lower = "y"; end
            8'h1A: begin letter = 1'b1; lower = "z"; end
            8'h16: begin plain = "1";   shifted = "!"; end
            8'h1E: begin plain = "2";   shifted = "@"; end
            8'h26: begin plain = "3";   shifted = "#"; end
            8'h25: begin plain = "4";   shifted = "$"; end
            8'h2E: begin plain = "5";   shifted = "%"; end
            8'h36: begin plain = "6";   shifted = "^"; end
            8'h3D: begin plain = "7";   shifted = "&"; end
            8'h3E: begin plain = "8";   shifted = "*"; end
            8'h46: begin plain = "9";   shifted = "("; end
            8'h45: begin plain = "0";   shifted = ")"; end
            8'h4E: begin plain = "-";   shifted = "_"; end
            8'h55: begin plain = "=";   shifted = "+"; end
            8'h54: begin plain = "[";   shifted = "{"; end
            8'h5B: begin plain = "]";   shifted = "}"; end
            8'h5D: begin plain = "\\";  shifted = "|"; end
            8'h4C: begin plain = ";";   shifted = ":"; end
            8'h52: begin plain = "'";   shifted = "\""; end
            8'h41: begin plain = ",";   shifted = "<"; end
            8'h49: begin plain = ".";   shifted = ">"; end
            8'h4A: begin plain = "/";   shifted = "?"; end
            8'h0E: begin plain = 8'h60; shifted = "~"; end
            8'h29: begin plain = " ";   shifted = " "; end
            8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
            8'h66: begin plain = 8'h08; shifted = 8'h08; end
            8'h0D: begin plain = 8'h09; shifted = 8'h09; end
            8'h76: begin plain = 8'h1B; shifted = 8'h1B; end
            default: ;
        endcase

        if (letter)
            ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
        else
            ascii = shift ? shifted : plain;
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 set-2 prefix bytes into make/break/repeat key events, tracks modifiers,
// counts new key presses and holds one event for a ready/valid consumer.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter bit REPEAT_EVENTS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic             ev_repeat,
    output logic [7:0]       ev_ascii,
    output logic [CNT_W-1:0] press_cnt,
    output logic             held_valid,
    output logic [8:0]       held_code,
    output logic             shift,
    output logic             caps,
    output logic             overflow
);

    state_t     state, state_nxt;
    logic       is_make, is_break;
    logic       cur_ext;
    logic [8:0] key;
    logic       held_match, is_repeat, new_make, emit, load;
    logic       shift_l, shift_r;
    logic [7:0] lut_ascii;

    assign cur_ext = (state == S_EXT) || (state == S_EXT_BRK);
    assign key     = {cur_ext, in_data};

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        state_nxt = state;
        is_make   = 1'b0;
        is_break  = 1'b0;
        if (in_valid) begin
            if (in_data == SC_EXT) begin
                state_nxt = S_EXT;
            end else if (in_data == SC_BRK) begin
                state_nxt = cur_ext ? S_EXT_BRK : S_BRK;
            end else if (is_ignored(in_data)) begin
                state_nxt = S_IDLE;
            end else begin
                state_nxt = S_IDLE;
                is_break  = (state == S_BRK) || (state == S_EXT_BRK);
                is_make   = !is_break;
            end
        end
    end

    assign held_match = held_valid && (held_code == key);
    assign is_repeat  = is_make && held_match;
    assign new_make   = is_make && !held_match;
    assign emit       = is_break || new_make || (is_repeat && REPEAT_EVENTS);
    assign load       = emit && (!ev_valid || ev_ready);
    assign shift      = shift_l || shift_r;

    // Lookup sees the modifier registers before this byte's own update lands.
    scancode_to_ascii u_ascii (
        .code  (in_data),
        .shift (shift),
        .caps  (caps),
        .ascii (lut_ascii)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            press_cnt  <= '0;
            held_valid <= 1'b0;
            held_code  <= '0;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            caps       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (new_make) begin
                held_code  <= key;
                held_valid <= 1'b1;
                press_cnt  <= press_cnt + 1'b1;
            end else if (is_break && held_match) begin
                held_valid <= 1'b0;
            end
            if (new_make && !cur_ext && in_data == SC_CAPS)
                caps <= !caps;
            if (in_data == SC_LSHIFT && (is_make || is_break))
                shift_l <= is_make;
            if (in_data == SC_RSHIFT && (is_make || is_break))
                shift_r <= is_make;
        end
    end

    // One-entry output register; a full, unaccepted register keeps the older event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_valid  <= 1'b0;
            ev_code   <= '0;
            ev_ext    <= 1'b0;
            ev_break  <= 1'b0;
            ev_repeat <= 1'b0;
            ev_ascii  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (load) begin
                ev_valid  <= 1'b1;
                ev_code   <= in_data;
                ev_ext    <= cur_ext;
                ev_break  <= is_break;
                ev_repeat <= is_repeat;
                ev_ascii  <= (is_make && !cur_ext) ? lut_ascii : 8'h00;
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end
            if (emit && ev_valid && !ev_ready)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder; a second instance with
// typematic repeats disabled shares the same stimulus.
module tb_ps2_scancode_decoder;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       ev_ready = 1'b1;

    logic       ev_valid, ev_ext, ev_break, ev_repeat, held_valid, shift, caps, overflow;
    logic [7:0] ev_code, ev_ascii, press_cnt;
    logic [8:0] held_code;

    logic       b_ev_valid, b_ev_ext, b_ev_break, b_ev_repeat, b_held_valid, b_shift, b_caps, b_overflow;
    logic [7:0] b_ev_code, b_ev_ascii, b_press_cnt;
    logic [8:0] b_held_code;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_a     = 0;
    int hs_b     = 0;
    int a0, b0;

    always #5 clk = !clk;

    ps2_scancode_decoder #(.CNT_W(8), .REPEAT_EVENTS(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_break(ev_break), .ev_repeat(ev_repeat), .ev_ascii(ev_ascii),
        .press_cnt(press_cnt), .held_valid(held_valid), .held_code(held_code),
        .shift(shift), .caps(caps), .overflow(overflow)
    );

    ps2_scancode_decoder #(.CNT_W(8), .REPEAT_EVENTS(1'b0)) dut_norep (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .ev_valid(b_ev_valid), .ev_ready(ev_ready), .ev_code(b_ev_code), .ev_ext(b_ev_ext),
        .ev_break(b_ev_break), .ev_repeat(b_ev_repeat), .ev_ascii(b_ev_ascii),
        .press_cnt(b_press_cnt), .held_valid(b_held_valid), .held_code(b_held_code),
        .shift(b_shift), .caps(b_caps), .overflow(b_overflow)
    );

    always @(posedge clk) begin
        if (ev_valid && ev_ready)     hs_a = hs_a + 1;
        if (b_ev_valid && ev_ready)   hs_b = hs_b + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one strobed byte; returns 1 time unit after the sampling edge.
    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ev_valid",  {15'd0, ev_valid}, 16'd0);
        check("rst_press_cnt", {8'd0, press_cnt}, 16'd0);
        check("rst_state",     {14'd0, dut.state}, {14'd0, S_IDLE});
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_no_event", {15'd0, ev_valid}, 16'd0);

        // plain make then break of 'a'
        send(8'h1C);
        check("a_make_valid", {15'd0, ev_valid}, 16'd1);
        check("a_make_code",  {8'd0, ev_code}, 16'h1C);
        check("a_make_ascii", {8'd0, ev_ascii}, 16'h61);
        check("a_make_break", {15'd0, ev_break}, 16'd0);
        send(8'hF0);
        check("prefix_no_event", {15'd0, ev_valid}, 16'd0);
        send(8'h1C);
        check("a_break_flags", {13'd0, ev_valid, ev_break, ev_repeat}, 16'b110);
        check("a_break_ascii", {8'd0, ev_ascii}, 16'h00);
        check("a_press_cnt",   {8'd0, press_cnt}, 16'd1);
        check("a_held_clear",  {15'd0, held_valid}, 16'd0);

        // shifted 'A'
        do_reset();
        send(8'h12);
        check("shift_make_ascii", {8'd0, ev_ascii}, 16'h00);
        check("shift_set",        {15'd0, shift}, 16'd1);
        send(8'h1C);
        check("shift_A_ascii", {8'd0, ev_ascii}, 16'h41);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        check("shift_released", {15'd0, shift}, 16'd0);
        check("shift_press_cnt", {8'd0, press_cnt}, 16'd2);

        // caps lock, then shift^caps
        do_reset();
        send(8'h58); send(8'hF0); send(8'h58);
        check("caps_on", {15'd0, caps}, 16'd1);
        send(8'h1C);
        check("caps_A_ascii", {8'd0, ev_ascii}, 16'h41);
        send(8'h12); send(8'h1C);
        check("caps_shift_a_ascii", {8'd0, ev_ascii}, 16'h61);
        send(8'h16);
        check("shift_digit_bang", {8'd0, ev_ascii}, 16'h21);

        // typematic repeat, with and without repeat events
        do_reset();
        a0 = hs_a;
        b0 = hs_b;
        send(8'h1C);
        check("rep1_flag", {15'd0, ev_repeat}, 16'd0);
        send(8'h1C);
        check("rep2_flag", {14'd0, ev_valid, ev_repeat}, 16'b11);
        check("rep2_ascii", {8'd0, ev_ascii}, 16'h61);
        send(8'h1C);
        check("rep3_flag", {14'd0, ev_valid, ev_repeat}, 16'b11);
        @(posedge clk);
        #1;
        check("rep_events_a", 16'(hs_a - a0), 16'd3);
        check("rep_events_b", 16'(hs_b - b0), 16'd1);
        check("rep_press_cnt",   {8'd0, press_cnt}, 16'd1);
        check("rep_press_cnt_b", {8'd0, b_press_cnt}, 16'd1);

        // extended key make/break
        do_reset();
        send(8'hE0); send(8'h75);
        check("ext_make", {5'd0, ev_valid, ev_ext, ev_break, ev_code}, {5'd0, 3'b110, 8'h75});
        check("ext_ascii", {8'd0, ev_ascii}, 16'h00);
        check("ext_held", {6'd0, held_valid, held_code}, {6'd0, 1'b1, 9'h175});
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_break", {5'd0, ev_valid, ev_ext, ev_break, ev_code}, {5'd0, 3'b111, 8'h75});
        check("ext_held_clear", {15'd0, held_valid}, 16'd0);

        // ignored bytes drop pending prefixes and emit nothing
        do_reset();
        send(8'hAA);
        check("ignored_no_event", {15'd0, ev_valid}, 16'd0);
        send(8'hE0); send(8'hFA);
        check("ignored_state_idle", {14'd0, dut.state}, {14'd0, S_IDLE});
        send(8'h1C);
        check("after_ignored_ext", {14'd0, ev_valid, ev_ext}, 16'b10);

        // press counter wraps modulo 256
        do_reset();
        for (int i = 0; i < 256; i++) send(i[0] ? 8'h32 : 8'h1C);
        check("cnt_wrap", {8'd0, press_cnt}, 16'd0);
        send(8'h21);
        check("cnt_wrap_plus1", {8'd0, press_cnt}, 16'd1);
        check("no_overflow_ready", {15'd0, overflow}, 16'd0);

        // overflow with stalled consumer, then reset mid-sequence
        do_reset();
        ev_ready = 1'b0;
        send(8'h1C); send(8'h32);
        check("ovf_code_kept", {8'd0, ev_code}, 16'h1C);
        check("ovf_sticky",    {14'd0, ev_valid, overflow}, 16'b11);
        check("ovf_press_cnt", {8'd0, press_cnt}, 16'd2);
        send(8'hE0); send(8'hF0);
        check("mid_seq_state", {14'd0, dut.state}, {14'd0, S_EXT_BRK});
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_state", {14'd0, dut.state}, {14'd0, S_IDLE});
        check("rst_async_outs", {8'd0, ev_valid, overflow, held_valid, shift, caps, ev_break, ev_ext, ev_repeat}, 16'd0);
        check("rst_async_cnt",  {8'd0, press_cnt}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ev_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
